traffic_input_ctrl: RTL and testbench
=====================================

// Module: traffic_input_ctrl
// PURPOSE
//  Front-end stage feeding the traffic-light FSM: prescales clk into a one-cycle
//  phase tick, debounces the pedestrian button and night-mode switch, and holds
//  a latched pedestrian request until the FSM acknowledges it (req/ack handshake).
//  Sits between the ui_in pins and the light-sequencing FSM, in the same clock domain.
// PARAMETERS
//  TICK_DIV  10_000_000  clk cycles per tick (>=2); counter width $clog2(TICK_DIV)
//  DEB_LEN   65_536      consecutive stable synced samples required to accept a change (>=1)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  reset, asynchronous assert, active-low
//  ena         in   1  design enable; low freezes prescaler and suppresses tick
//  btn_raw     in   1  pedestrian push-button, asynchronous, active-high
//  night_raw   in   1  night-mode switch, asynchronous, active-high
//  tick_sync   in   1  1-cycle pulse from FSM on state change; restarts prescaler
//  ped_ack     in   1  1-cycle pulse from FSM: request consumed
//  tick        out  1  1-cycle phase-time enable
//  ped_req     out  1  latched pedestrian request level
//  night_mode  out  1  debounced night-switch level
//  req_count   out  8  accepted-request count (PED_COUNT_EN only, else 0)
// BEHAVIOUR
//  Reset (rst_n low, any time, async): tick=0, ped_req=0, night_mode=0, req_count=0,
//   prescaler=0, synchronizers=0, debouncers in ST_LO with counter 0. Mid-operation
//   reset discards any pending request or partial debounce.
//  Prescaler: cnt counts 0..TICK_DIV-1 while ena; tick=1 on the cycle cnt==TICK_DIV-1
//   (registered), cnt wraps to 0. ena=0: cnt holds, tick=0. tick_sync=1: cnt<=0, tick=0
//   that cycle (tick_sync overrides wrap). First tick after reset TICK_DIV cycles after release.
//  Sync: each raw input passes 2 flops; synced value valid 2 edges after raw changes.
//  Debouncer FSM (per input): ST_LO, WAIT_HI, ST_HI, WAIT_LO.
//   ST_LO: sync=1 -> WAIT_HI, count=1 (DEB_LEN==1: straight to ST_HI).
//   WAIT_HI: sync=0 -> ST_LO (bounce, count=0); count==DEB_LEN-1 & sync=1 -> ST_HI, emit
//    rise pulse; else count++. ST_HI/WAIT_LO symmetric, emit fall pulse.
//   Level out = (state==ST_HI||state==WAIT_LO). Raw change before edge k -> level changes
//   at edge k+1+DEB_LEN. Pulses shorter than DEB_LEN synced cycles are ignored.
//  night_mode = debounced night level, unaffected by ena.
//  ped_req: set on edge after btn rise pulse; cleared on edge with ped_ack=1.
//   Rise and ack in the same cycle -> ped_req=1 (new press wins). Rise while ped_req=1
//   -> no change (not queued). Release of button never clears ped_req. ack while 0 -> no-op.
//  Counter widths fixed per parameter; no arithmetic overflow except req_count (saturates).
// CONFIGURATION
//  TRAFFIC_PED_COUNT_EN defined: req_count increments (saturating at 255) each time
//   ped_req goes 0->1; cleared only by reset.
//  Not defined: req_count tied to 8'd0, counter logic absent.
// STRUCTURE
//  traffic_pkg: debouncer state enum (ST_LO, WAIT_HI, ST_HI, WAIT_LO), default
//   TICK_DIV/DEB_LEN constants, REQ_COUNT_W=8.
//  Sub-module input_debounce (sync flops + FSM + counter, outputs level/rise/fall),
//   instantiated twice (btn, night). Prescaler and request latch stay in top.
// TESTING  (bench uses TICK_DIV=4, DEB_LEN=3)
//  Release reset at edge 0, ena=1 -> tick high cycles 3,7,11,...; ena=0 at 5 -> no tick until resumed.
//  tick_sync pulse at cycle 6 -> no tick at 7; next tick at cycle 10.
//  btn_raw high before edge 10, held -> ped_req=1 after edge 15; ped_ack at 20 -> ped_req=0 after 20.
//  btn_raw high for 2 cycles only -> ped_req stays 0; night_raw 2-cycle glitch -> night_mode stays 0.
//  New press rise coincides with ped_ack -> ped_req remains 1; req_count=2 (PED_COUNT_EN).
//  Assert rst_n=0 asynchronously while ped_req=1 & mid-debounce -> all outputs 0 immediately.

Source files
------------

// File: rtl/traffic_input_ctrl_pkg.sv
// rtl/traffic_input_ctrl_pkg.sv - shared types and defaults for the traffic input front-end
// Purpose: debouncer state encoding, default prescale/debounce lengths and the
//          request-counter width used by traffic_input_ctrl and input_debounce.
// Ports:   none (package).
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_LO,
      WAIT_HI,
      ST_HI,
      WAIT_LO
   } deb_state_e;

   localparam int unsigned TICK_DIV_DEF = 10_000_000;
   localparam int unsigned DEB_LEN_DEF  = 65_536;
   localparam int unsigned REQ_COUNT_W  = 8;

endpackage

// File: rtl/traffic_input_ctrl_if.sv
// rtl/traffic_input_ctrl_if.sv - signal bundle between the pins/FSM side and the input front-end
// Purpose: groups the enable, raw inputs, FSM handshake and front-end outputs.
// Ports:   master - drives ena/btn_raw/night_raw/tick_sync/ped_ack, observes outputs
//          slave  - the front-end: consumes inputs, drives tick/ped_req/night_mode/req_count
interface traffic_input_ctrl_if;
   import traffic_pkg::*;

   logic                   ena;
   logic                   btn_raw;
   logic                   night_raw;
   logic                   tick_sync;
   logic                   ped_ack;
   logic                   tick;
   logic                   ped_req;
   logic                   night_mode;
   logic [REQ_COUNT_W-1:0] req_count;

   modport master (
      output ena, btn_raw, night_raw, tick_sync, ped_ack,
      input  tick, ped_req, night_mode, req_count
   );

   modport slave (
      input  ena, btn_raw, night_raw, tick_sync, ped_ack,
      output tick, ped_req, night_mode, req_count
   );

endinterface

// File: rtl/traffic_input_ctrl_debounce.sv
// rtl/traffic_input_ctrl_debounce.sv - two-flop synchronizer plus four-state debouncer
// Purpose: accepts a level change on raw_i only after DEB_LEN consecutive equal
//          synchronized samples; emits one-cycle rise/fall pulses alongside the level.
// Ports:   clk, rst_n (async active-low), raw_i (asynchronous input),
//          level_o (debounced level), rise_o / fall_o (one-cycle change pulses)
module input_debounce
   import traffic_pkg::*;
#(
   parameter int unsigned DEB_LEN = DEB_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned    CW     = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
   localparam logic [CW-1:0]  LAST   = CW'(DEB_LEN - 1);
   localparam bit             SINGLE = (DEB_LEN == 1);

   logic          sync1_q, sync2_q;
   deb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= ST_LO;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // The first differing sample already counts as 1, so acceptance happens on
   // the DEB_LEN-th consecutive differing sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ST_LO: begin
            if (sync2_q) begin
               if (SINGLE) begin
                  state_d = ST_HI;
                  rise_d  = 1'b1;
               end else begin
                  state_d = WAIT_HI;
                  cnt_d   = CW'(1);
               end
            end
         end
         WAIT_HI: begin
            if (!sync2_q) begin
               state_d = ST_LO;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d = ST_HI;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_HI: begin
            if (!sync2_q) begin
               if (SINGLE) begin
                  state_d = ST_LO;
                  fall_d  = 1'b1;
               end else begin
                  state_d = WAIT_LO;
                  cnt_d   = CW'(1);
               end
            end
         end
         WAIT_LO: begin
            if (sync2_q) begin
               state_d = ST_HI;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d = ST_LO;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_LO;
            cnt_d   = '0;
         end
      endcase
   end

   assign level_o = (state_q == ST_HI) || (state_q == WAIT_LO);
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/traffic_input_ctrl.sv
// rtl/traffic_input_ctrl.sv - phase-tick prescaler, input debouncing and pedestrian request latch
// Purpose: feeds the light-sequencing FSM with a one-cycle phase tick, a debounced
//          night-mode level and a latched pedestrian request cleared by ped_ack.
// Ports:   clk, rst_n (async active-low)
//          bus (slave): ena, btn_raw, night_raw, tick_sync, ped_ack in;
//                       tick, ped_req, night_mode, req_count out
// Config:  TRAFFIC_PED_COUNT_EN - when defined, req_count counts accepted requests
//          (saturating); otherwise req_count is constant zero.
module traffic_input_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEF,
   parameter int unsigned DEB_LEN  = DEB_LEN_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   traffic_input_ctrl_if.slave bus
);

   localparam int unsigned   PW    = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_cnt_q, pre_cnt_d;
   logic          tick_q, tick_d;
   logic          ped_req_q, ped_req_d;
   logic          btn_level, btn_rise, btn_fall;
   logic          night_level, night_rise, night_fall;
   logic          unused_pulses;

   input_debounce #(.DEB_LEN(DEB_LEN)) u_btn_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (bus.btn_raw),
      .level_o (btn_level),
      .rise_o  (btn_rise),
      .fall_o  (btn_fall)
   );

   input_debounce #(.DEB_LEN(DEB_LEN)) u_night_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (bus.night_raw),
      .level_o (night_level),
      .rise_o  (night_rise),
      .fall_o  (night_fall)
   );

   assign unused_pulses = &{1'b0, btn_level, btn_fall, night_rise, night_fall};

   // tick_sync realigns the phase to the FSM's state change and beats a wrap.
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      tick_d    = 1'b0;
      if (bus.tick_sync) begin
         pre_cnt_d = '0;
      end else if (bus.ena) begin
         if (pre_cnt_q == PLAST) begin
            pre_cnt_d = '0;
            tick_d    = 1'b1;
         end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
         end
      end
   end

   // A fresh press wins over a simultaneous acknowledge.
   assign ped_req_d = btn_rise | (ped_req_q & ~bus.ped_ack);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q <= '0;
         tick_q    <= 1'b0;
         ped_req_q <= 1'b0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         tick_q    <= tick_d;
         ped_req_q <= ped_req_d;
      end
   end

   assign bus.tick       = tick_q;
   assign bus.ped_req    = ped_req_q;
   assign bus.night_mode = night_level;

`ifdef TRAFFIC_PED_COUNT_EN
   logic [REQ_COUNT_W-1:0] req_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_cnt_q <= '0;
      end else if (btn_rise && !ped_req_q && (req_cnt_q != '1)) begin
         req_cnt_q <= req_cnt_q + REQ_COUNT_W'(1);
      end
   end

   assign bus.req_count = req_cnt_q;
`else
   assign bus.req_count = '0;
`endif

endmodule

// File: tb/tb_traffic_input_ctrl.sv
// tb/tb_traffic_input_ctrl.sv - scoreboard bench for traffic_input_ctrl (TICK_DIV=4, DEB_LEN=3)
module tb_traffic_input_ctrl;
   import traffic_pkg::*;

   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned DEB_LEN  = 3;
   localparam int          LAST_MAIN = 138;
   localparam int          LAST_POST = 9;
`ifdef TRAFFIC_PED_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   traffic_input_ctrl_if bus_if ();

   traffic_input_ctrl #(.TICK_DIV(TICK_DIV), .DEB_LEN(DEB_LEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   typedef struct {
      int         cyc;
      logic       tick;
      logic       ped_req;
      logic       night;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected outputs after edge c of the main run, from the stimulus timeline.
   function automatic exp_t exp_main(int c);
      exp_t e;
      e.cyc     = c;
      e.tick    = (c == 3) || (c == 10) || (c == 18);
      e.ped_req = (c >= 35 && c < 40) || (c >= 85 && c < 120) || (c >= 135);
      e.night   = (c >= 64 && c < 74);
      if (!CNT_EN)       e.cnt = 8'd0;
      else if (c >= 135) e.cnt = 8'd3;
      else if (c >= 85)  e.cnt = 8'd2;
      else if (c >= 35)  e.cnt = 8'd1;
      else               e.cnt = 8'd0;
      return e;
   endfunction

   // After the mid-run reset: night_raw held high, fresh debounce and prescale.
   function automatic exp_t exp_post(int c);
      exp_t e;
      e.cyc     = c;
      e.tick    = (c % 4) == 3;
      e.ped_req = 1'b0;
      e.night   = (c >= 4);
      e.cnt     = 8'd0;
      return e;
   endfunction

   // Inputs seen by edge n of the main run.
   task automatic drive_main(input int n);
      bus_if.ena       = (n < 12) || (n >= 16 && n < 20);
      bus_if.tick_sync = (n == 6);
      bus_if.btn_raw   = (n >= 30 && n < 42) || (n >= 50 && n < 52) || (n >= 80 && n < 88) ||
                         (n >= 96 && n < 104) || (n >= 112 && n < 120) || (n >= 130);
      bus_if.night_raw = (n >= 50 && n < 52) || (n >= 60 && n < 70) || (n >= 136);
      bus_if.ped_ack   = (n == 40) || (n == 85) || (n == 101) || (n == 120) || (n == 124);
   endtask

   task automatic compare_front(input string ph);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({ph, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk($sformatf("%s_c%0d_tick", ph, e.cyc), bus_if.tick, e.tick);
         chk($sformatf("%s_c%0d_ped_req", ph, e.cyc), bus_if.ped_req, e.ped_req);
         chk($sformatf("%s_c%0d_night", ph, e.cyc), bus_if.night_mode, e.night);
         chk($sformatf("%s_c%0d_req_count", ph, e.cyc), bus_if.req_count, e.cnt);
      end
   endtask

   task automatic chk_all_zero(input string ph);
      chk({ph, "_tick"}, bus_if.tick, 1'b0);
      chk({ph, "_ped_req"}, bus_if.ped_req, 1'b0);
      chk({ph, "_night"}, bus_if.night_mode, 1'b0);
      chk({ph, "_req_count"}, bus_if.req_count, 8'd0);
   endtask

   initial begin
      bus_if.ena       = 1'b0;
      bus_if.btn_raw   = 1'b0;
      bus_if.night_raw = 1'b0;
      bus_if.tick_sync = 1'b0;
      bus_if.ped_ack   = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");

      rst_n = 1'b1;
      drive_main(0);
      sb_q.push_back(exp_main(0));
      for (int c = 0; c <= LAST_MAIN; c++) begin
         @(negedge clk);
         compare_front("main");
         if (c < LAST_MAIN) begin
            drive_main(c + 1);
            sb_q.push_back(exp_main(c + 1));
         end
      end

      // ped_req is high and the night debouncer is mid-count here.
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      bus_if.btn_raw   = 1'b0;
      bus_if.night_raw = 1'b1;
      bus_if.ena       = 1'b1;
      bus_if.ped_ack   = 1'b0;
      bus_if.tick_sync = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("rst_held");

      rst_n = 1'b1;
      sb_q.push_back(exp_post(0));
      for (int c = 0; c <= LAST_POST; c++) begin
         @(negedge clk);
         compare_front("post");
         if (c < LAST_POST) sb_q.push_back(exp_post(c + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
